// File: rtl/x_delay_line_meas.sv
// Delay-line measurement back end: snapshots are polarity-normalised, turned into tap counts,
// and reduced to min/max/sum/avg/bubble over a 2^LOG2_SAMPLES window.
module x_delay_line_meas #(
   parameter int LOG2_SAMPLES = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [31:0]               i_dl_data,
   input  logic                      i_dl_valid,
   input  logic                      i_ready,
   output logic                      o_busy,
   output logic                      o_valid,
   output logic [5:0]                o_min,
   output logic [5:0]                o_max,
   output logic [6+LOG2_SAMPLES-1:0] o_sum,
   output logic [5:0]                o_avg,
   output logic                      o_bubble
);

   localparam int SW = 6 + LOG2_SAMPLES;
   localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [31:0] s1_norm;
   logic        s1_valid;
   logic [5:0]  pop;
   logic [32:0] norm_inc;
   logic        bub;

   logic [5:0]  s2_code;
   logic        s2_bubble;
   logic        s2_valid;

   logic [LOG2_SAMPLES-1:0] cnt;
   logic [5:0]  acc_min;
   logic [5:0]  acc_max;
   logic [SW-1:0] acc_sum;
   logic        acc_bub;

   logic        open_win;
   logic        take;
   logic        last;
   logic [5:0]  nxt_min;
   logic [5:0]  nxt_max;
   logic [SW-1:0] nxt_sum;
   logic        nxt_bub;

   // Stage 1: fold polarity so the filled run always starts at bit 0
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_norm  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= i_dl_valid;
         if (i_dl_valid) begin
            s1_norm <= i_dl_data[0] ? i_dl_data : ~i_dl_data;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < 32; i++) begin
         pop = pop + 6'(s1_norm[i]);
      end
   end

   // 33-bit increment keeps an all-ones snapshot from looking like a bubble
   assign norm_inc = {1'b0, s1_norm} + 33'd1;
   assign bub      = |({1'b0, s1_norm} & norm_inc);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_code   <= '0;
         s2_bubble <= 1'b0;
         s2_valid  <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_code   <= pop;
            s2_bubble <= bub;
         end
      end
   end

   assign open_win = (state_q == IDLE) && i_start;
   assign take     = (state_q == ACCUM) && s2_valid;
   assign last     = take && (cnt == CNT_LAST);

   assign nxt_min = (s2_code < acc_min) ? s2_code : acc_min;
   assign nxt_max = (s2_code > acc_max) ? s2_code : acc_max;
   assign nxt_sum = acc_sum + SW'(s2_code);
   assign nxt_bub = acc_bub | s2_bubble;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_start) state_d = ACCUM;
         ACCUM:   if (last) state_d = DONE;
         DONE:    if (i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt     <= '0;
         acc_min <= 6'h3F;
         acc_max <= '0;
         acc_sum <= '0;
         acc_bub <= 1'b0;
      end else if (open_win) begin
         cnt     <= '0;
         acc_min <= 6'h3F;
         acc_max <= '0;
         acc_sum <= '0;
         acc_bub <= 1'b0;
      end else if (take) begin
         cnt     <= cnt + 1'b1;
         acc_min <= nxt_min;
         acc_max <= nxt_max;
         acc_sum <= nxt_sum;
         acc_bub <= nxt_bub;
      end
   end

   // Result registers include the closing sample and hold after readout
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_min    <= '0;
         o_max    <= '0;
         o_sum    <= '0;
         o_avg    <= '0;
         o_bubble <= 1'b0;
      end else if (last) begin
         o_min    <= nxt_min;
         o_max    <= nxt_max;
         o_sum    <= nxt_sum;
         o_avg    <= nxt_sum[SW-1:LOG2_SAMPLES];
         o_bubble <= nxt_bub;
      end
   end

   assign o_busy  = (state_q == ACCUM);
   assign o_valid = (state_q == DONE);

endmodule

// File: tb/tb_x_delay_line_meas.sv
// Bench for x_delay_line_meas with a 4-sample window: vector table plus
// hand sequences for reset, in-flight samples and handshake corners.
module tb_x_delay_line_meas;

   localparam int L2 = 2;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dl_data;
   logic        dl_valid;
   logic        ready;
   logic        busy;
   logic        valid;
   logic [5:0]  mn;
   logic [5:0]  mx;
   logic [7:0]  sum;
   logic [5:0]  avg;
   logic        bubble;

   typedef struct {
      logic [31:0] s [4];
      int          gap [4];
      logic [5:0]  e_min;
      logic [5:0]  e_max;
      logic [7:0]  e_sum;
      logic [5:0]  e_avg;
      logic        e_bub;
   } vec_t;

   typedef struct {
      logic [5:0] e_min;
      logic [5:0] e_max;
      logic [7:0] e_sum;
      logic [5:0] e_avg;
      logic       e_bub;
   } res_t;

   vec_t vt [4];
   res_t sb [$];
   int   n_cmp = 0;
   int   n_mis = 0;
   logic pv = 1'b0;

   x_delay_line_meas #(.LOG2_SAMPLES(L2)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_dl_data  (dl_data),
      .i_dl_valid (dl_valid),
      .i_ready    (ready),
      .o_busy     (busy),
      .o_valid    (valid),
      .o_min      (mn),
      .o_max      (mx),
      .o_sum      (sum),
      .o_avg      (avg),
      .o_bubble   (bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each new result is checked against the oldest expectation
   always @(negedge clk) begin
      if (valid && !pv) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t r;
            r = sb.pop_front();
            chk("o_min", 32'(mn), 32'(r.e_min));
            chk("o_max", 32'(mx), 32'(r.e_max));
            chk("o_sum", 32'(sum), 32'(r.e_sum));
            chk("o_avg", 32'(avg), 32'(r.e_avg));
            chk("o_bubble", 32'(bubble), 32'(r.e_bub));
         end
      end
      pv = valid;
   end

   task automatic push_exp(input int k);
      res_t r;
      r.e_min = vt[k].e_min;
      r.e_max = vt[k].e_max;
      r.e_sum = vt[k].e_sum;
      r.e_avg = vt[k].e_avg;
      r.e_bub = vt[k].e_bub;
      sb.push_back(r);
   endtask

   // Called right after the edge that sampled the last sample
   task automatic finish_win(input bit hs);
      int k;
      dl_valid = 1'b0;
      chk("valid_early", 32'(valid), 32'd0);
      k = 0;
      while (!valid && k < 10) begin
         step();
         k++;
      end
      chk("latency", 32'(k), 32'd2);
      chk("busy_done", 32'(busy), 32'd0);
      if (hs) begin
         ready = 1'b1;
         step();
         ready = 1'b0;
         chk("valid_after_hs", 32'(valid), 32'd0);
      end
   endtask

   task automatic run_win(input int k, input bit hs);
      push_exp(k);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < vt[k].gap[i]; g++) begin
            dl_valid = 1'b0;
            dl_data  = $urandom;
            step();
         end
         dl_valid = 1'b1;
         dl_data  = vt[k].s[i];
         step();
      end
      finish_win(hs);
   endtask

   initial begin
      vt[0].s = '{32'h0000_00FF, 32'hFFFF_FF00, 32'h0000_0FFF, 32'hFFFF_FFF0};
      vt[0].gap = '{0, 0, 0, 0};
      vt[0].e_min = 6'd4; vt[0].e_max = 6'd12; vt[0].e_sum = 8'd32;
      vt[0].e_avg = 6'd8; vt[0].e_bub = 1'b0;

      vt[1].s = '{32'h0000_00F7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      vt[1].gap = '{0, 0, 0, 0};
      vt[1].e_min = 6'd1; vt[1].e_max = 6'd32; vt[1].e_sum = 8'd41;
      vt[1].e_avg = 6'd10; vt[1].e_bub = 1'b1;

      vt[2] = vt[0];
      vt[2].gap = '{0, 2, 1, 3};

      vt[3].s = '{32'hFFFF_0000, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_FF0F};
      vt[3].gap = '{1, 0, 2, 0};
      vt[3].e_min = 6'd1; vt[3].e_max = 6'd16; vt[3].e_sum = 8'd31;
      vt[3].e_avg = 6'd7; vt[3].e_bub = 1'b1;

      rst = 1'b1;
      start = 1'b0;
      dl_data = '0;
      dl_valid = 1'b0;
      ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_min", 32'(mn), 32'd0);
      chk("rst_max", 32'(mx), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_avg", 32'(avg), 32'd0);
      chk("rst_bubble", 32'(bubble), 32'd0);

      // Reset in the middle of a window with samples flowing
      start = 1'b1;
      step();
      start = 1'b0;
      dl_valid = 1'b1;
      dl_data = 32'hFFFF_FFFF;
      repeat (3) step();
      rst = 1'b1;
      repeat (3) begin
         step();
         chk("midrst_busy", 32'(busy), 32'd0);
         chk("midrst_valid", 32'(valid), 32'd0);
         chk("midrst_sum", 32'(sum), 32'd0);
      end
      dl_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("postrst_busy", 32'(busy), 32'd0);

      for (int k = 0; k < 4; k++) begin
         run_win(k, 1'b1);
      end

      // X reaches stage 2 before start is taken; s0 and s1 are in flight
      push_exp(0);
      dl_valid = 1'b1;
      dl_data = 32'hFFFF_FFFF;
      step();
      dl_data = vt[0].s[0];
      step();
      dl_data = vt[0].s[1];
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_inflight", 32'(busy), 32'd1);
      dl_data = vt[0].s[2];
      step();
      dl_data = vt[0].s[3];
      step();
      finish_win(1'b1);

      // Result held under back-pressure; samples in DONE are junk
      run_win(1, 1'b0);
      dl_valid = 1'b1;
      dl_data = 32'h0000_FFFF;
      for (int c = 0; c < 10; c++) begin
         start = c[0];
         step();
         chk("hold_valid", 32'(valid), 32'd1);
         chk("hold_busy", 32'(busy), 32'd0);
      end
      start = 1'b0;
      chk("hold_sum", 32'(sum), 32'd41);
      chk("hold_min", 32'(mn), 32'd1);
      chk("hold_max", 32'(mx), 32'd32);
      ready = 1'b1;
      start = 1'b1;
      step();
      ready = 1'b0;
      start = 1'b0;
      chk("hs_valid", 32'(valid), 32'd0);
      chk("hs_busy", 32'(busy), 32'd0);
      repeat (2) begin
         step();
         chk("idle_busy", 32'(busy), 32'd0);
      end
      dl_valid = 1'b0;
      repeat (3) step();
      run_win(3, 1'b1);

      repeat (3) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
